// File: rtl/result_collector.sv
// Collects N_SIZE result rows from the systolic array, then drains them over valid/ready.
// Optional row-sequence checking is enabled with `RESULT_COLLECTOR_CHECK_EN.
module result_collector #(
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned N_SIZE    = 5,
    localparam int unsigned IDX_W    = $clog2(N_SIZE),
    localparam int unsigned ROW_W    = N_SIZE * OUT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_sel,
    input  logic [ROW_W-1:0] in_row,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] out_row,
    output logic [IDX_W-1:0] out_row_idx,
    output logic             out_last,
    output logic             busy,
    output logic             err,
    input  logic             err_clr
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_SIZE - 1);

    typedef enum logic [1:0] {StIdle, StFill, StDrain} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [ROW_W-1:0] row_buf_q [N_SIZE];
    logic             wr_en;
    logic             handshake;

`ifdef RESULT_COLLECTOR_CHECK_EN
    logic err_q, err_d, err_set;
`else
    logic sel_in_range;
    // In-range guard keeps stray indices from addressing past the buffer.
    assign sel_in_range = 32'(in_sel) < N_SIZE;
`endif

    assign handshake = (state_q == StDrain) && out_ready;

    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        wr_en    = 1'b0;
`ifdef RESULT_COLLECTOR_CHECK_EN
        err_set  = 1'b0;
`endif
        case (state_q)
            StIdle: begin
`ifdef RESULT_COLLECTOR_CHECK_EN
                if (in_valid) begin
                    if (in_sel == '0) begin
                        wr_en    = 1'b1;
                        wr_idx_d = IDX_W'(1);
                        state_d  = StFill;
                    end else begin
                        err_set = 1'b1;
                    end
                end
`else
                if (in_valid && sel_in_range) begin
                    wr_en    = 1'b1;
                    wr_idx_d = IDX_W'(1);
                    state_d  = StFill;
                end
`endif
            end
            StFill: begin
`ifdef RESULT_COLLECTOR_CHECK_EN
                if (!in_valid || (in_sel != wr_idx_q)) begin
                    err_set = 1'b1;
                end else begin
`else
                if (in_valid && sel_in_range) begin
`endif
                    wr_en    = 1'b1;
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (in_sel == LastIdx) begin
                        rd_idx_d = '0;
                        state_d  = StDrain;
                    end
                end
            end
            StDrain: begin
`ifdef RESULT_COLLECTOR_CHECK_EN
                if (in_valid) err_set = 1'b1;
`endif
                if (handshake) begin
                    if (rd_idx_q == LastIdx) begin
                        rd_idx_d = '0;
                        wr_idx_d = '0;
                        state_d  = StIdle;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    // Row storage needs no reset: it is only read in DRAIN, after a full fill.
    always_ff @(posedge clk) begin
        if (wr_en) row_buf_q[in_sel] <= in_row;
    end

`ifdef RESULT_COLLECTOR_CHECK_EN
    // A new error wins over a simultaneous clear.
    assign err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err            = 1'b0;
`endif

    assign out_valid   = (state_q == StDrain);
    assign out_row     = out_valid ? row_buf_q[rd_idx_q] : '0;
    assign out_row_idx = rd_idx_q;
    assign out_last    = out_valid && (rd_idx_q == LastIdx);
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector (N_SIZE=5, OUT_WIDTH=32); covers both
// RESULT_COLLECTOR_CHECK_EN builds.
module tb_result_collector;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [2:0]   in_sel;
    logic [159:0] in_row;
    logic         out_valid;
    logic         out_ready;
    logic [159:0] out_row;
    logic [2:0]   out_row_idx;
    logic         out_last;
    logic         busy;
    logic         err;
    logic         err_clr;

    int nvec = 0;
    int nerr = 0;

`ifdef RESULT_COLLECTOR_CHECK_EN
    localparam logic ExpDrainErr = 1'b1;
`else
    localparam logic ExpDrainErr = 1'b0;
`endif

    result_collector #(.OUT_WIDTH(32), .N_SIZE(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sel     (in_sel),
        .in_row     (in_row),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row),
        .out_row_idx(out_row_idx),
        .out_last   (out_last),
        .busy       (busy),
        .err        (err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [159:0] mkrow(input int k, input int base);
        logic [159:0] r;
        for (int j = 0; j < 5; j++) r[j*32 +: 32] = 32'(base + 16 * k + j);
        return r;
    endfunction

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input int base);
        in_valid = 1'b1;
        in_sel   = 3'(k);
        in_row   = mkrow(k, base);
        cyc();
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_sel   = '0;
        in_row   = '0;
    endtask

    task automatic fill(input int base);
        for (int k = 0; k < 5; k++) begin
            send(k, base);
            if (k == 0) check("busy_after_row0", 160'(busy), 160'(1));
            if (k < 4)  check("no_valid_in_fill", 160'(out_valid), 160'(0));
        end
        idle_in();
    endtask

    // Drains with out_ready high; optionally drives junk rows during DRAIN.
    task automatic drain_check(input int base, input bit inject);
        out_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            check("drain_valid", 160'(out_valid), 160'(1));
            check("drain_idx", 160'(out_row_idx), 160'(r));
            check("drain_row", out_row, mkrow(r, base));
            check("drain_last", 160'(out_last), 160'(r == 4));
            if (inject) begin
                in_valid = 1'b1;
                in_sel   = '0;
                in_row   = '1;
            end
            cyc();
        end
        idle_in();
        check("post_drain_busy", 160'(busy), 160'(0));
        check("post_drain_valid", 160'(out_valid), 160'(0));
        check("post_drain_row", out_row, 160'(0));
    endtask

    initial begin
        int hs;
        int c;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        idle_in();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 160'(out_valid), 160'(0));
        check("rst_row", out_row, 160'(0));
        check("rst_idx", 160'(out_row_idx), 160'(0));
        check("rst_last", 160'(out_last), 160'(0));
        check("rst_busy", 160'(busy), 160'(0));
        check("rst_err", 160'(err), 160'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("idle_busy", 160'(busy), 160'(0));
            check("idle_valid", 160'(out_valid), 160'(0));
        end

        // Nominal fill and drain
        out_ready = 1'b1;
        fill(0);
        drain_check(0, 1'b0);
        check("nominal_err", 160'(err), 160'(0));

        // Backpressure with ready pattern 1,0,0,1,0,0,...
        fill(100);
        hs = 0;
        c  = 0;
        while (hs < 5 && c < 40) begin
            out_ready = (c % 3 == 0);
            check("bp_valid", 160'(out_valid), 160'(1));
            check("bp_idx", 160'(out_row_idx), 160'(hs));
            check("bp_row", out_row, mkrow(hs, 100));
            check("bp_last", 160'(out_last), 160'(hs == 4));
            cyc();
            if (out_ready) hs++;
            c++;
        end
        check("bp_handshakes", 160'(hs), 160'(5));
        check("bp_busy", 160'(busy), 160'(0));
        out_ready = 1'b1;

        // Rows arriving during DRAIN are dropped
        fill(600);
        drain_check(600, 1'b1);
        check("drain_inject_err", 160'(err), 160'(ExpDrainErr));
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("err_clr", 160'(err), 160'(0));

        // Out-of-order row sequence 0,1,3
`ifdef RESULT_COLLECTOR_CHECK_EN
        send(0, 400);
        send(1, 400);
        send(3, 900);
        check("ooo_err", 160'(err), 160'(1));
        check("ooo_busy", 160'(busy), 160'(1));
        send(2, 400);
        send(3, 400);
        check("ooo_still_fill", 160'(out_valid), 160'(0));
        send(4, 400);
        idle_in();
        drain_check(400, 1'b0);
        check("ooo_err_sticky", 160'(err), 160'(1));
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("ooo_err_clr", 160'(err), 160'(0));
`else
        send(0, 500);
        send(1, 500);
        send(3, 500);
        check("ooo_err", 160'(err), 160'(0));
        check("ooo_fill", 160'(out_valid), 160'(0));
        send(2, 500);
        check("ooo_still_fill", 160'(out_valid), 160'(0));
        send(4, 500);
        idle_in();
        drain_check(500, 1'b0);
        check("ooo_err_after", 160'(err), 160'(0));
`endif

        // Reset in the middle of DRAIN
        fill(200);
        cyc();
        cyc();
        check("pre_rst_idx", 160'(out_row_idx), 160'(2));
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", 160'(out_valid), 160'(0));
        check("midrst_busy", 160'(busy), 160'(0));
        check("midrst_row", out_row, 160'(0));
        check("midrst_idx", 160'(out_row_idx), 160'(0));
        rst_n = 1'b1;
        cyc();
        fill(300);
        drain_check(300, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
